// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on ser_bit.
// Latency: word accepted at edge E shows its first bit in cycle E+2 and its last bit in cycle E+1+WIDTH.
// Backpressure: in_ready drops while the one-word holding register is full; a held word follows with no idle gap.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Registered state and its next-state values.
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] sh_q,        sh_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] sh_shifted;

  // The holding register is the only entry point, so ready is simply "hold is empty".
  // Reset is folded in so nothing is ever accepted during a reset cycle.
  assign in_ready = ~hold_full_q & ~reset;
  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  // Move the next bit to the output end, zero-filling so an idle shifter always reads 0.
  assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sh_q[WIDTH-1:1]};

  // Next-state logic: accept into hold, reload hold into the shifter, shift one bit per cycle.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    // An accept can never coincide with a reload: accept needs hold empty, reload needs it full.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          sh_d        = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (!last_bit) begin
          sh_d  = sh_shifted;
          cnt_d = cnt_q + CNT_ONE;
        end else if (hold_full_q) begin
          // Chain straight into the held word so the bit stream has no gap.
          sh_d        = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset; a reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Outputs decode registered state only; the shifter is cleared whenever it goes idle,
  // so ser_bit reads 0 outside live bits without extra gating.
  assign ser_bit     = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign ser_valid   = (state_q == ST_SHIFT);
  assign frame_start = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign busy        = (state_q == ST_SHIFT) || hold_full_q;

  // A data bit is only ever presented while the shifter is live.
  a_bit_only_when_valid : assert property (@(posedge clk) disable iff (reset)
    ser_bit |-> ser_valid);

  // A full holding register always blocks the producer.
  a_no_accept_when_full : assert property (@(posedge clk) disable iff (reset)
    hold_full_q |-> !in_ready);

endmodule
